// File: rtl/cv32e40x_pkg.sv
// Shared core package: OBI data-side request/response types and
// instantiation defaults used by the LSU-side transaction tracker.
package cv32e40x_pkg;

   // Default cap on outstanding OBI data transactions
   localparam int DATA_TRANS_MAX_OUTSTANDING = 2;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [5:0]  atop;
      logic [1:0]  memtype;
      logic [2:0]  prot;
      logic        dbg;
   } obi_data_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        exokay;
   } obi_data_resp_t;

endpackage

// File: rtl/cv32e40x_flag_fifo.sv
// DEPTH x 1-bit circular FIFO holding the per-transaction "silent" flag
// in issue order. Occupancy is tracked by the parent, so this block has
// no full/empty logic of its own.
module cv32e40x_flag_fifo
#(
   parameter int DEPTH = 2
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic push_flag,
   input  logic pop,
   output logic pop_flag
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] flags;
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;

   // Pointers wrap modulo DEPTH, which need not be a power of two
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   // Write the flag of each accepted transaction at the write pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= '0;
         wptr  <= '0;
      end else if (push) begin
         flags[wptr] <= push_flag;
         wptr        <= next_ptr(wptr);
      end
   end

   // Advance the read pointer as each response retires its entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr <= '0;
      end else if (pop) begin
         rptr <= next_ptr(rptr);
      end
   end

   // Oldest outstanding flag, valid whenever the parent count is non-zero
   assign pop_flag = flags[rptr];

endmodule

// File: rtl/cv32e40x_data_trans_tracker.sv
// Sits between the LSU and the OBI data adapter. Caps outstanding OBI
// transactions at DEPTH, drops responses of silent (bufferable) writes
// towards the LSU while flagging their errors, and reports outstanding
// count / idle for fence, debug and sleep gating.
module cv32e40x_data_trans_tracker
   import cv32e40x_pkg::*;
#(
   parameter int DEPTH = DATA_TRANS_MAX_OUTSTANDING
)
(
   input  logic                       clk,
   input  logic                       rst_n,

   input  logic                       lsu_trans_valid_i,
   output logic                       lsu_trans_ready_o,
   input  obi_data_req_t              lsu_trans_i,
   input  logic                       lsu_trans_silent_i,

   output logic                       bus_trans_valid_o,
   input  logic                       bus_trans_ready_i,
   output obi_data_req_t              bus_trans_o,

   input  logic                       bus_resp_valid_i,
   input  obi_data_resp_t             bus_resp_i,

   output logic                       lsu_resp_valid_o,
   output obi_data_resp_t             lsu_resp_o,
   output logic                       silent_err_o,

   output logic [$clog2(DEPTH+1)-1:0] outstanding_cnt_o,
   output logic                       idle_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CNT_W-1:0] cnt;
   logic             space;
   logic             accept;
   logic             pop;
   logic             head_silent;

   // Request path is pure gating: no register, so A-channel stability
   // comes straight from the LSU holding its request until accepted.
   assign space             = (cnt < CNT_W'(DEPTH));
   assign bus_trans_valid_o = lsu_trans_valid_i & space;
   assign lsu_trans_ready_o = bus_trans_ready_i & space;
   assign bus_trans_o       = lsu_trans_i;
   assign accept            = lsu_trans_valid_i & bus_trans_ready_i & space;

   // A response with nothing outstanding is ignored rather than popping
   assign pop = bus_resp_valid_i & (cnt != '0);

   // Silent responses are swallowed; only their error is surfaced
   assign lsu_resp_valid_o = pop & ~head_silent;
   assign lsu_resp_o       = bus_resp_i;
   assign silent_err_o     = pop & head_silent & bus_resp_i.err;

   assign outstanding_cnt_o = cnt;
   assign idle_o            = (cnt == '0) & ~lsu_trans_valid_i;

   // Outstanding counter; a simultaneous accept and pop leave it unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (accept && !pop) begin
         cnt <= cnt + CNT_W'(1);
      end else if (!accept && pop) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   cv32e40x_flag_fifo #(
      .DEPTH     (DEPTH)
   ) flag_fifo_i (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (accept),
      .push_flag (lsu_trans_silent_i),
      .pop       (pop),
      .pop_flag  (head_silent)
   );

   // The LSU must not withdraw a request before it has been accepted
   a_valid_held : assert property (
      @(posedge clk) disable iff (!rst_n)
      (lsu_trans_valid_i && !lsu_trans_ready_o) |=> lsu_trans_valid_i
   ) else $error("[cv32e40x_data_trans_tracker] lsu_trans_valid_i withdrawn before accept");

   // A response must always belong to an outstanding transaction
   a_resp_expected : assert property (
      @(posedge clk) disable iff (!rst_n)
      bus_resp_valid_i |-> (cnt != '0)
   ) else $warning("[cv32e40x_data_trans_tracker] response received with no outstanding transaction, ignored");

endmodule
